// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared definitions for the experiment-4 FIFO write and read
//                controllers: default pointer width, the pointer type and a
//                helper that derives memory depth from pointer width.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Default pointer width: MSB is the wrap bit, the rest address memory.
    localparam int c_PTR_W = 4;

    // Pointer type shared by the write-side and read-side controllers.
    typedef logic [c_PTR_W-1:0] ptr_t;

    // Number of memory entries addressed by a pointer of the given width.
    function automatic int fifo_depth(input int size);
        return 1 << (size - 1);
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_write_ctrl_full_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : full_cmp
//  Description : Combinational full comparator. The FIFO is full when the
//                address bits of both pointers match but the wrap bits differ,
//                i.e. the writer is exactly one lap ahead of the reader.
//                Mirrors the read-side empty comparator.
//  Ports       : w_pointer - write pointer (wrap bit in MSB)
//                r_pointer - read pointer  (wrap bit in MSB)
//                f_flag    - FIFO full
//  Revision    : 1.0 - initial release
// ============================================================================
module full_cmp #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] w_pointer,
    input  logic [SIZE-1:0] r_pointer,
    output logic            f_flag
);

    always_comb begin
        f_flag = (w_pointer[SIZE-1] != r_pointer[SIZE-1]) &&
                 (w_pointer[SIZE-2:0] == r_pointer[SIZE-2:0]);
    end

endmodule : full_cmp
`default_nettype wire

// File: rtl/fifo_write_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_write_ctrl
//  Description : Write-side controller for the experiment-4 FIFO. Owns the
//                write pointer, gates memory writes, and produces the full
//                flag, occupancy count and a sticky overflow error.
//  Ports       : clk, rst    - clock (rising edge), async active-high reset
//                wr_req      - producer write request
//                clr_err     - clears ovf_err (a same-cycle overflow wins)
//                r_pointer   - read pointer from read side (same clk domain)
//                w_pointer   - registered write pointer, wrap bit in MSB
//                w_addr      - memory write address
//                mem_we      - memory write enable
//                f_flag      - FIFO full
//                count       - occupancy, 0..DEPTH
//                ovf_err     - sticky overflow (write requested while full)
//                af_flag     - almost full (count >= AF_LEVEL)
//  Options     : FIFO_ALMOST_FULL_EN - when defined, af_flag is driven from
//                the occupancy count; otherwise it is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_write_ctrl
    import fifo_pkg::*;
#(
    parameter int SIZE     = 4,
    parameter int AF_LEVEL = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_req,
    input  logic            clr_err,
    input  logic [SIZE-1:0] r_pointer,
    output logic [SIZE-1:0] w_pointer,
    output logic [SIZE-2:0] w_addr,
    output logic            mem_we,
    output logic            f_flag,
    output logic [SIZE-1:0] count,
    output logic            ovf_err,
    output logic            af_flag
);

    logic [SIZE-1:0] r_wptr;
    logic            r_ovf_err;
    logic            w_full;
    logic            w_we;
    logic            w_reject;
    logic [SIZE-1:0] w_count;

    full_cmp #(
        .SIZE      (SIZE)
    ) u_full_cmp (
        .w_pointer (r_wptr),
        .r_pointer (r_pointer),
        .f_flag    (w_full)
    );

    always_comb begin
        w_we     = wr_req & ~w_full;
        w_reject = wr_req &  w_full;
        // Modulo-2^SIZE difference; the wrap bit makes a full FIFO read DEPTH.
        w_count  = r_wptr - r_pointer;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
        end else if (w_we) begin
            r_wptr <= r_wptr + 1'b1;
        end
    end

    // Set has priority over clear so an overflow in the clearing cycle is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_err <= 1'b0;
        end else if (w_reject) begin
            r_ovf_err <= 1'b1;
        end else if (clr_err) begin
            r_ovf_err <= 1'b0;
        end
    end

`ifdef FIFO_ALMOST_FULL_EN
    always_comb begin
        af_flag = (w_count >= SIZE'(AF_LEVEL));
    end
`else
    always_comb begin
        af_flag = 1'b0;
    end
`endif

    assign w_pointer = r_wptr;
    assign w_addr    = r_wptr[SIZE-2:0];
    assign mem_we    = w_we;
    assign f_flag    = w_full;
    assign count     = w_count;
    assign ovf_err   = r_ovf_err;

endmodule : fifo_write_ctrl
`default_nettype wire

// File: tb/tb_fifo_write_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_write_ctrl
//  Description : Directed self-checking bench for fifo_write_ctrl. Inputs
//                change 1 ns after the rising edge; outputs are sampled 2 ns
//                after the rising edge, well clear of the next edge.
//  Options     : FIFO_ALMOST_FULL_EN - selects which af_flag check is run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_write_ctrl;

    localparam int c_SIZE = 4;

    logic              clk;
    logic              rst;
    logic              wr_req;
    logic              clr_err;
    logic [c_SIZE-1:0] r_pointer;
    logic [c_SIZE-1:0] w_pointer;
    logic [c_SIZE-2:0] w_addr;
    logic              mem_we;
    logic              f_flag;
    logic [c_SIZE-1:0] count;
    logic              ovf_err;
    logic              af_flag;

    int total;
    int bad;

    fifo_write_ctrl #(
        .SIZE      (c_SIZE),
        .AF_LEVEL  (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_req    (wr_req),
        .clr_err   (clr_err),
        .r_pointer (r_pointer),
        .w_pointer (w_pointer),
        .w_addr    (w_addr),
        .mem_we    (mem_we),
        .f_flag    (f_flag),
        .count     (count),
        .ovf_err   (ovf_err),
        .af_flag   (af_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_req = 1'b0; clr_err = 1'b0; r_pointer = '0;
        #1;
        total++; if (w_pointer !== 4'd0) begin bad++; $display("FAIL rst_init_wptr got=%0d exp=0", w_pointer); end
        total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL rst_init_ovf got=%b exp=0", ovf_err); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_init_we got=%b exp=0", mem_we); end
        total++; if (af_flag !== 1'b0) begin bad++; $display("FAIL rst_init_af got=%b exp=0", af_flag); end
        tick();
        rst = 1'b0;
        // Five accepted writes, then a mid-cycle asynchronous reset.
        wr_req = 1'b1;
        repeat (5) tick();
        wr_req = 1'b0;
        #1;
        total++; if (w_pointer !== 4'd5) begin bad++; $display("FAIL pre_rst_wptr got=%0d exp=5", w_pointer); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (w_pointer !== 4'd0) begin bad++; $display("FAIL mid_rst_wptr got=%0d exp=0", w_pointer); end
        total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL mid_rst_ovf got=%b exp=0", ovf_err); end
        total++; if (f_flag !== 1'b0) begin bad++; $display("FAIL mid_rst_full got=%b exp=0", f_flag); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL mid_rst_count got=%0d exp=0", count); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_fill();
        r_pointer = '0;
        wr_req    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL fill_we[%0d] got=%b exp=1", i, mem_we); end
            total++; if (w_addr !== 3'(i)) begin bad++; $display("FAIL fill_addr[%0d] got=%0d exp=%0d", i, w_addr, i); end
            tick();
        end
        wr_req = 1'b0;
        #1;
        total++; if (w_pointer !== 4'b1000) begin bad++; $display("FAIL fill_wptr got=%0d exp=8", w_pointer); end
        total++; if (f_flag !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", f_flag); end
        total++; if (count !== 4'd8) begin bad++; $display("FAIL fill_count got=%0d exp=8", count); end
        total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL fill_ovf got=%b exp=0", ovf_err); end
    endtask

    task automatic test_overflow();
        tick();
        wr_req = 1'b1;
        #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL ovf_we got=%b exp=0", mem_we); end
        tick();
        wr_req = 1'b0;
        #1;
        total++; if (w_pointer !== 4'd8) begin bad++; $display("FAIL ovf_wptr got=%0d exp=8", w_pointer); end
        total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", ovf_err); end
        tick();
        total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", ovf_err); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        #1;
        total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", ovf_err); end
        tick();
        wr_req  = 1'b1;
        clr_err = 1'b1;
        tick();
        wr_req  = 1'b0;
        clr_err = 1'b0;
        #1;
        total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b exp=1", ovf_err); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic test_simultaneous();
        // Cycle N: reader is consuming (r still 0), writer requests.
        wr_req = 1'b1;
        #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL sim_n_we got=%b exp=0", mem_we); end
        tick();
        // Cycle N+1: read side has advanced.
        r_pointer = 4'd1;
        #1;
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL sim_n1_we got=%b exp=1", mem_we); end
        total++; if (count !== 4'd7) begin bad++; $display("FAIL sim_n1_count got=%0d exp=7", count); end
        tick();
        wr_req = 1'b0;
        #1;
        total++; if (w_pointer !== 4'd9) begin bad++; $display("FAIL sim_wptr got=%0d exp=9", w_pointer); end
        total++; if (count !== 4'd8) begin bad++; $display("FAIL sim_count got=%0d exp=8", count); end
        total++; if (f_flag !== 1'b1) begin bad++; $display("FAIL sim_full got=%b exp=1", f_flag); end
        total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL sim_ovf got=%b exp=1", ovf_err); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic test_wrap();
        // Realign both sides at zero, fill, then interleave read-then-write.
        rst = 1'b1; r_pointer = '0;
        tick();
        rst = 1'b0;
        wr_req = 1'b1;
        repeat (8) tick();
        for (int j = 0; j < 8; j++) begin
            r_pointer = 4'(j + 1);
            #1;
            total++; if (f_flag !== 1'b0) begin bad++; $display("FAIL wrap_full[%0d] got=%b exp=0", j, f_flag); end
            total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL wrap_we[%0d] got=%b exp=1", j, mem_we); end
            if (j == 7) begin
                total++; if (w_pointer !== 4'd15) begin bad++; $display("FAIL wrap_pre got=%0d exp=15", w_pointer); end
            end
            tick();
        end
        wr_req = 1'b0;
        #1;
        total++; if (w_pointer !== 4'd0) begin bad++; $display("FAIL wrap_wptr got=%0d exp=0", w_pointer); end
        total++; if (f_flag !== 1'b1) begin bad++; $display("FAIL wrap_full got=%b exp=1", f_flag); end
        total++; if (count !== 4'd8) begin bad++; $display("FAIL wrap_count got=%0d exp=8", count); end
    endtask

    task automatic test_count_modulo();
        // w=0 throughout; count = (0 - r) mod 16.
        r_pointer = 4'd13;
        #1;
        total++; if (count !== 4'd3) begin bad++; $display("FAIL cnt_r13 got=%0d exp=3", count); end
        total++; if (f_flag !== 1'b0) begin bad++; $display("FAIL cnt_r13_full got=%b exp=0", f_flag); end
        r_pointer = 4'd0;
        #1;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL cnt_empty got=%0d exp=0", count); end
        total++; if (f_flag !== 1'b0) begin bad++; $display("FAIL cnt_empty_full got=%b exp=0", f_flag); end
        r_pointer = 4'd11;
        #1;
        total++; if (count !== 4'd5) begin bad++; $display("FAIL cnt_r11 got=%0d exp=5", count); end
    endtask

    task automatic test_almost_full();
`ifdef FIFO_ALMOST_FULL_EN
        r_pointer = 4'd11;   // count 5
        #1;
        total++; if (af_flag !== 1'b0) begin bad++; $display("FAIL af_at5 got=%b exp=0", af_flag); end
        r_pointer = 4'd10;   // count 6
        #1;
        total++; if (af_flag !== 1'b1) begin bad++; $display("FAIL af_at6 got=%b exp=1", af_flag); end
        r_pointer = 4'd8;    // count 8
        #1;
        total++; if (af_flag !== 1'b1) begin bad++; $display("FAIL af_at8 got=%b exp=1", af_flag); end
`else
        r_pointer = 4'd8;    // count 8
        #1;
        total++; if (count !== 4'd8) begin bad++; $display("FAIL af_cnt8 got=%0d exp=8", count); end
        total++; if (af_flag !== 1'b0) begin bad++; $display("FAIL af_off got=%b exp=0", af_flag); end
`endif
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fill();
        test_overflow();
        test_simultaneous();
        test_wrap();
        test_count_modulo();
        test_almost_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fifo_write_ctrl
`default_nettype wire

// File: doc/fifo_write_ctrl.md
Name: fifo_write_ctrl

Overview:
- Write-side controller for the experiment-4 FIFO.
- Counterpart to the read-side empty comparator.
- Owns the write pointer, gates memory writes, and produces the full flag, occupancy count and a sticky overflow error.
- Sits between the producer and the FIFO memory; receives the read pointer from the read side.

Parameters:
SIZE, 4, pointer width in bits; MSB is the wrap bit, lower SIZE-1 bits address memory; DEPTH = 2^(SIZE-1) = 8
AF_LEVEL, 6, almost-full threshold in entries; used only with FIFO_ALMOST_FULL_EN; legal range 1..DEPTH

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
wr_req  input  1  producer write request, one entry per cycle when high
clr_err  input  1  clears ovf_err
r_pointer  input  SIZE  read pointer from read side, same clk domain, wrap bit in MSB
w_pointer  output  SIZE  registered write pointer, wrap bit in MSB
w_addr  output  SIZE-1  memory write address = w_pointer[SIZE-2:0]
mem_we  output  1  memory write enable
f_flag  output  1  FIFO full
count  output  SIZE  occupancy, 0..DEPTH
ovf_err  output  1  sticky overflow: write requested while full
af_flag  output  1  almost full (see Optional Feature)

Behaviour:
- One clock domain (clk); rst asynchronous, active-high.
- Reset values: w_pointer=0, ovf_err=0. With r_pointer=0, combinational outputs then evaluate to f_flag=0, count=0, mem_we=0 (with wr_req=0), af_flag=0.
- f_flag is combinational from registered w_pointer and r_pointer:
  - f_flag=1 iff w_pointer[SIZE-1] != r_pointer[SIZE-1] and w_pointer[SIZE-2:0] == r_pointer[SIZE-2:0].
  - Zero-cycle latency relative to pointer changes.
- count = (w_pointer - r_pointer) modulo 2^SIZE, unsigned. Never exceeds DEPTH for legal read-side behaviour.
- mem_we = wr_req & ~f_flag (combinational). Memory captures data at w_addr on the same clk edge.
- Accepted write (mem_we=1): w_pointer increments by 1 on the next rising edge. Rolls from 2^SIZE-1 to 0; the wrap bit toggles every DEPTH writes.
- Rejected write (wr_req=1 & f_flag=1):
  - w_pointer holds.
  - Memory is not written.
  - ovf_err sets on the next edge.
- ovf_err is sticky until a clr_err edge. If clr_err and a rejected write occur in the same cycle, set wins (ovf_err=1).
- Simultaneous read and write while full: f_flag reflects the current r_pointer only, so the write is rejected that cycle. It is accepted the cycle after the read side advances r_pointer.
- Simultaneous read and write while not full: the write is accepted. count changes by net (+1 -1) once both pointers update.
- Reset mid-operation: the pointer clears immediately (asynchronous) and any write pending that cycle is discarded. The read side is reset by the same rst, so pointers realign at 0.
- No state machine beyond the pointer register and the error bit. Both are implemented in always_ff; flags and count in always_comb.

Optional Feature:
- Macro FIFO_ALMOST_FULL_EN.
- Defined: af_flag = (count >= AF_LEVEL), combinational, 0 on reset.
- Undefined: af_flag tied 0 and AF_LEVEL ignored.
- The port is present in both builds.

Decomposition:
- Package fifo_pkg:
  - localparam function for DEPTH from SIZE
  - a pointer typedef (logic [SIZE-1:0]) shared with the read-side controller
- Sub-module full_cmp: combinational full comparator (pointers in, f_flag out), mirroring the read-side empty comparator.
- Pointer register, count, mem_we and ovf_err stay in fifo_write_ctrl.

Test Plan:
- Reset: assert rst mid-cycle with w_pointer=5 -> w_pointer=0 immediately, ovf_err=0, f_flag=0, count=0.
- Fill: r_pointer=0, wr_req=1 for 8 cycles -> mem_we high 8 cycles, w_addr 0..7, w_pointer=4'b1000, f_flag=1, count=8.
- Overflow: while full, wr_req=1 for 1 cycle -> mem_we=0, w_pointer stays 8, ovf_err=1 next edge. clr_err pulse -> ovf_err=0. Overflow and clr_err in the same cycle -> ovf_err=1.
- Wrap: r_pointer steps to 4'b1000 after 16 writes with interleaved reads -> w_pointer wraps 15->0, f_flag=1 when w_pointer=0 and r_pointer=8, count=8.
- Simultaneous: full at w=8, r=0; cycle N: r_pointer->1 and wr_req=1 -> write rejected at N, accepted at N+1, w_pointer=9, count=8, f_flag=1.
- Almost-full (FIFO_ALMOST_FULL_EN, AF_LEVEL=6): count 5->6 -> af_flag 0->1. Without the macro, af_flag stays 0 at count=8.
